audio_frame_scheduler: RTL and testbench

//  Buffers I2S receiver samples into a circular sample RAM (dual-port BRAM) and schedules overlapping

---
 rtl/audio_frame_scheduler_pkg.sv | 13 +
 rtl/audio_frame_scheduler_if.sv | 36 +++
 rtl/audio_frame_scheduler_frame_reader.sv | 83 ++++++++
 rtl/audio_frame_scheduler.sv | 146 ++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_frame_scheduler_pkg.sv
// Shared types and defaults for the audio frame scheduler.
package audio_frame_scheduler_pkg;

  localparam int SAMPLE_WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/audio_frame_scheduler_if.sv
// Receiver/RAM/engine signal bundle of the audio frame scheduler.
interface audio_frame_scheduler_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int ADDR_W       = 12
);
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid_in;
  logic                    engine_ready_in;
  logic                    overrun_clr_in;
  logic                    ram_we_out;
  logic [ADDR_W-1:0]       ram_waddr_out;
  logic [SAMPLE_WIDTH-1:0] ram_wdata_out;
  logic [ADDR_W-1:0]       ram_raddr_out;
  logic [SAMPLE_WIDTH-1:0] ram_rdata_in;
  logic [SAMPLE_WIDTH-1:0] frame_data_out;
  logic                    frame_valid_out;
  logic                    frame_first_out;
  logic                    frame_last_out;
  logic                    busy_out;
  logic                    overrun_out;

  // master: the scheduler itself; slave: receiver, RAM and engine side
  modport master (
    input  sample_in, sample_valid_in, engine_ready_in, overrun_clr_in, ram_rdata_in,
    output ram_we_out, ram_waddr_out, ram_wdata_out, ram_raddr_out,
    output frame_data_out, frame_valid_out, frame_first_out, frame_last_out,
    output busy_out, overrun_out
  );

  modport slave (
    output sample_in, sample_valid_in, engine_ready_in, overrun_clr_in, ram_rdata_in,
    input  ram_we_out, ram_waddr_out, ram_wdata_out, ram_raddr_out,
    input  frame_data_out, frame_valid_out, frame_first_out, frame_last_out,
    input  busy_out, overrun_out
  );
endinterface

// File: rtl/audio_frame_scheduler_frame_reader.sv
// Issues WINDOW consecutive RAM read addresses from a base and delays the
// valid/first/last markers to line up with the RAM read data.
module audio_frame_scheduler_frame_reader #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int BUF_DEPTH    = 4096,
  parameter int WINDOW       = 2048,
  parameter int RD_LATENCY   = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         start,
  input  logic [$clog2(BUF_DEPTH)-1:0] base,
  input  logic [SAMPLE_WIDTH-1:0]      rdata,
  output logic [$clog2(BUF_DEPTH)-1:0] raddr,
  output logic                         issue_done,
  output logic [SAMPLE_WIDTH-1:0]      frame_data,
  output logic                         frame_valid,
  output logic                         frame_first,
  output logic                         frame_last
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic          iss_p0;
  logic [AW-1:0] addr_p0;
  logic [CW-1:0] cnt_p0;
  logic          first_p0;
  logic          last_p0;

  logic [RD_LATENCY:1] vld_p;
  logic [RD_LATENCY:1] first_p;
  logic [RD_LATENCY:1] last_p;

  assign first_p0   = iss_p0 && (cnt_p0 == '0);
  assign last_p0    = iss_p0 && (cnt_p0 == CW'(WINDOW - 1));
  assign issue_done = last_p0;
  assign raddr      = addr_p0;

  // stage p0: address issue, one address per cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      iss_p0  <= 1'b0;
      addr_p0 <= '0;
      cnt_p0  <= '0;
    end else if (start) begin
      iss_p0  <= 1'b1;
      addr_p0 <= base;
      cnt_p0  <= '0;
    end else if (iss_p0) begin
      if (last_p0) begin
        iss_p0 <= 1'b0;
      end else begin
        addr_p0 <= addr_p0 + AW'(1);
        cnt_p0  <= cnt_p0 + CW'(1);
      end
    end
  end

  // stages p1..pRD_LATENCY: markers travel alongside the RAM read latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p   <= '0;
      first_p <= '0;
      last_p  <= '0;
    end else begin
      vld_p[1]   <= iss_p0;
      first_p[1] <= first_p0;
      last_p[1]  <= last_p0;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
        last_p[i]  <= last_p[i-1];
      end
    end
  end

  assign frame_valid = vld_p[RD_LATENCY];
  assign frame_first = first_p[RD_LATENCY];
  assign frame_last  = last_p[RD_LATENCY];
  // RAM data passes straight through; held at zero outside valid beats
  assign frame_data  = frame_valid ? rdata : '0;

endmodule

// File: rtl/audio_frame_scheduler.sv
// Circular sample buffer writer and overlapping-frame scheduler feeding the
// pitch-detection engine; frames of WINDOW samples are triggered every HOP samples.
module audio_frame_scheduler
  import audio_frame_scheduler_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int BUF_DEPTH    = 4096,
  parameter int WINDOW       = 2048,
  parameter int HOP          = 512,
  parameter int RD_LATENCY   = 2
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  audio_frame_scheduler_if.master bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int FW = $clog2(WINDOW + 1);
  localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int DW = $clog2(RD_LATENCY + 1);

  sched_state_t            state;
  logic [AW-1:0]           wr_ptr;
  logic [FW-1:0]           fill;
  logic [FW-1:0]           fill_nxt;
  logic [HW-1:0]           hop_cnt;
  logic                    pending;
  logic [AW-1:0]           pend_base;
  logic [AW-1:0]           new_base;
  logic [DW-1:0]           drain_cnt;
  logic                    overrun;
  logic                    trig;
  logic                    start;
  logic                    issue_done;

  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [SAMPLE_WIDTH-1:0] ram_wdata;
  logic [AW-1:0]           ram_raddr;
  logic [SAMPLE_WIDTH-1:0] frame_data;
  logic                    frame_valid;
  logic                    frame_first;
  logic                    frame_last;

  assign fill_nxt = (fill == FW'(WINDOW)) ? fill : fill + FW'(1);
  assign trig     = bus.sample_valid_in && (hop_cnt == HW'(HOP - 1)) && (fill_nxt == FW'(WINDOW));
  assign start    = (state == S_IDLE) && pending && bus.engine_ready_in;
  // oldest sample of the window that ends with the sample being written now
  assign new_base = wr_ptr + AW'(1) - AW'(WINDOW);

  // write path: sample registered one cycle onto the RAM write port
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      hop_cnt   <= '0;
    end else begin
      ram_we <= bus.sample_valid_in;
      if (bus.sample_valid_in) begin
        ram_waddr <= wr_ptr;
        ram_wdata <= bus.sample_in;
        wr_ptr    <= wr_ptr + AW'(1);
        fill      <= fill_nxt;
        hop_cnt   <= (hop_cnt == HW'(HOP - 1)) ? '0 : hop_cnt + HW'(1);
      end
    end
  end

  // A newer trigger always replaces an untaken one; taking and re-arming on the
  // same edge is not an overrun. A new overrun beats a simultaneous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending   <= 1'b0;
      pend_base <= '0;
      overrun   <= 1'b0;
    end else begin
      if (trig) begin
        pending   <= 1'b1;
        pend_base <= new_base;
      end else if (start) begin
        pending <= 1'b0;
      end
      if (trig && pending && !start) begin
        overrun <= 1'b1;
      end else if (bus.overrun_clr_in) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= S_FILL;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_FILL:   if (bus.sample_valid_in && (fill_nxt == FW'(WINDOW))) state <= S_IDLE;
        S_IDLE:   if (start) state <= S_STREAM;
        S_STREAM: begin
          if (issue_done) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(RD_LATENCY - 1)) state <= S_IDLE;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        default:  state <= S_FILL;
      endcase
    end
  end

  audio_frame_scheduler_frame_reader #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .BUF_DEPTH    (BUF_DEPTH),
    .WINDOW       (WINDOW),
    .RD_LATENCY   (RD_LATENCY)
  ) u_reader (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .start       (start),
    .base        (pend_base),
    .rdata       (bus.ram_rdata_in),
    .raddr       (ram_raddr),
    .issue_done  (issue_done),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  assign bus.ram_we_out      = ram_we;
  assign bus.ram_waddr_out   = ram_waddr;
  assign bus.ram_wdata_out   = ram_wdata;
  assign bus.ram_raddr_out   = ram_raddr;
  assign bus.frame_data_out  = frame_data;
  assign bus.frame_valid_out = frame_valid;
  assign bus.frame_first_out = frame_first;
  assign bus.frame_last_out  = frame_last;
  assign bus.busy_out        = (state == S_STREAM) || (state == S_DRAIN);
  assign bus.overrun_out     = overrun;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Randomized bench for audio_frame_scheduler (WINDOW=8, HOP=4, BUF_DEPTH=16, RD_LATENCY=2)
// with a sample-history reference model and a RAM model.
module tb_audio_frame_scheduler;
  localparam int SW = 24;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int D  = 16;
  localparam int RL = 2;

  logic clk;
  logic rst_n;

  audio_frame_scheduler_if #(.SAMPLE_WIDTH(SW), .ADDR_W(4)) bus ();

  audio_frame_scheduler #(
    .SAMPLE_WIDTH (SW),
    .BUF_DEPTH    (D),
    .WINDOW       (W),
    .HOP          (H),
    .RD_LATENCY   (RL)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dual-port RAM model with two-cycle read latency
  logic [SW-1:0] mem [0:D-1];
  logic [SW-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (bus.ram_we_out) mem[bus.ram_waddr_out] <= bus.ram_wdata_out;
    rd_p1 <= mem[bus.ram_raddr_out];
    rd_p2 <= rd_p1;
  end
  assign bus.ram_rdata_in = rd_p2;

  int checks = 0;
  int errors = 0;

  // model state: sample history indexed by global sample number
  logic [SW-1:0] sent [0:4095];
  int  g = 0;          // global samples driven
  int  g0 = 0;         // global index of first sample after last reset
  int  n = 0;          // samples since reset
  int  exp_q[$];       // expected frame bases (samples since reset)
  bit  hold = 0;       // engine held off: a new trigger supersedes an untaken one
  bit  loose = 0;      // frame ordering not predicted, only consistency checked
  bit  ov_exp = 0;

  // monitor state
  int  wr_r = 0, wr_g = 0;
  int  frames_done = 0, last_base = -1, mon_beat = 0;
  int  cur_g = 0, cur_r = 0;
  bit  in_frame = 0;
  logic [3:0] ra_d1 = '0, ra_d2 = '0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // drive one sample for one cycle, then idle for gap cycles (call at posedge+1)
  task automatic send(input int gap, input bit clr);
    logic [SW-1:0] v;
    v = {12'($urandom), 12'(g)};
    sent[g] = v;
    bus.sample_in       = v;
    bus.sample_valid_in = 1'b1;
    bus.overrun_clr_in  = clr;
    g++;
    n++;
    if (clr) ov_exp = 1'b0;
    if (n >= W && (n % H) == 0 && !loose) begin
      if (hold) begin
        if (exp_q.size() > 0) ov_exp = 1'b1;
        exp_q.delete();
      end
      exp_q.push_back(n - W);
    end
    @(posedge clk); #1;
    bus.sample_valid_in = 1'b0;
    bus.overrun_clr_in  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_n(input int cnt);
    for (int i = 0; i < cnt; i++) send($urandom_range(6, 3), 1'b0);
  endtask

  task automatic pulse_clr();
    bus.overrun_clr_in = 1'b1;
    ov_exp = 1'b0;
    @(posedge clk); #1;
    bus.overrun_clr_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    n = 0;
    ov_exp = 1'b0;
    g0 = g;
    wr_r = 0;
    wr_g = g;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int k;
    k = 0;
    while (frames_done < target && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) begin @(posedge clk); #1; end
    check(tag, frames_done, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, bus.frame_valid_out, 0);
    check({tag, "_first"}, bus.frame_first_out, 0);
    check({tag, "_last"},  bus.frame_last_out, 0);
    check({tag, "_data"},  bus.frame_data_out, 0);
    check({tag, "_busy"},  bus.busy_out, 0);
    check({tag, "_ovr"},   bus.overrun_out, 0);
    check({tag, "_we"},    bus.ram_we_out, 0);
    check({tag, "_waddr"}, bus.ram_waddr_out, 0);
    check({tag, "_wdata"}, bus.ram_wdata_out, 0);
    check({tag, "_raddr"}, bus.ram_raddr_out, 0);
  endtask

  // output monitor: write port and frame stream against the sample history
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
        mon_beat = 0;
        ra_d1 = '0;
        ra_d2 = '0;
      end else begin
        if (bus.ram_we_out) begin
          check("waddr", bus.ram_waddr_out, wr_r % D);
          check("wdata", bus.ram_wdata_out, sent[wr_g % 4096]);
          wr_r++;
          wr_g++;
        end
        if (in_frame) check("contig", bus.frame_valid_out, 1);
        if (bus.frame_valid_out) begin
          if (mon_beat == 0) begin
            cur_g = int'(bus.frame_data_out[11:0]);
            cur_r = cur_g - g0;
            if (loose) begin
              check("base_align", (cur_r + W) % H, 0);
              check("base_range", (cur_r >= 0) && (cur_r + W <= n), 1);
            end else begin
              check("frame_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) check("base", cur_r, exp_q.pop_front());
            end
          end
          check("first", bus.frame_first_out, mon_beat == 0);
          check("last",  bus.frame_last_out, mon_beat == W - 1);
          check("data",  bus.frame_data_out, sent[(cur_g + mon_beat) % 4096]);
          check("raddr", ra_d2, (cur_r + mon_beat) % D);
          mon_beat++;
          in_frame = 1;
          if (mon_beat == W) begin
            in_frame = 0;
            mon_beat = 0;
            frames_done++;
            last_base = cur_r;
          end
        end
        ra_d2 = ra_d1;
        ra_d1 = bus.ram_raddr_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit reached", $time);
    $fatal(1);
  end

  initial begin
    int f0;
    int k;
    rst_n = 1'b0;
    bus.sample_in       = '0;
    bus.sample_valid_in = 1'b0;
    bus.engine_ready_in = 1'b0;
    bus.overrun_clr_in  = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("reset");
    apply_reset();

    // first frame after WINDOW samples, then one per HOP, including address wrap
    bus.engine_ready_in = 1'b1;
    send_n(7);
    check("no_early_frame", frames_done, 0);
    send_n(1);
    wait_frames(1, "frame1");
    check("frame1_base", last_base, 0);
    send_n(4);
    wait_frames(2, "frame2");
    check("frame2_base", last_base, 4);
    send_n(28);
    wait_frames(9, "wrap_frames");
    check("wrap_last_base", last_base, 32);
    check("no_overrun", bus.overrun_out, ov_exp);
    check("idle_busy", bus.busy_out, 0);

    // engine held off across two triggers: only the newer frame streams
    apply_reset();
    bus.engine_ready_in = 1'b0;
    hold = 1'b1;
    send_n(12);
    repeat (20) begin @(posedge clk); #1; end
    check("held_no_frame", frames_done, 9);
    check("overrun_set", bus.overrun_out, ov_exp);
    hold = 1'b0;
    bus.engine_ready_in = 1'b1;
    wait_frames(10, "released_frame");
    check("released_base", last_base, 4);
    repeat (20) begin @(posedge clk); #1; end
    check("single_release", frames_done, 10);
    check("overrun_sticky", bus.overrun_out, 1);
    pulse_clr();
    check("overrun_clr", bus.overrun_out, ov_exp);

    // clear arriving together with a fresh overrun: set wins
    bus.engine_ready_in = 1'b0;
    hold = 1'b1;
    send_n(4);
    check("pending_no_ovr", bus.overrun_out, ov_exp);
    send_n(3);
    send(3, 1'b1);
    check("set_wins", bus.overrun_out, ov_exp);
    hold = 1'b0;
    bus.engine_ready_in = 1'b1;
    wait_frames(11, "setwin_frame");
    check("setwin_base", last_base, 12);
    pulse_clr();
    check("overrun_clr2", bus.overrun_out, ov_exp);

    // sample every cycle while frames stream
    loose = 1'b1;
    exp_q.delete();
    f0 = frames_done;
    for (int i = 0; i < 4; i++) send(2, 1'b0);
    for (int i = 0; i < 20; i++) send(0, 1'b0);
    repeat (40) begin @(posedge clk); #1; end
    check("burst_frames", frames_done >= f0 + 2, 1);
    check("burst_idle", bus.busy_out, 0);
    loose = 1'b0;

    // reset during the 4th beat of a frame
    apply_reset();
    send_n(8);
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (mon_beat != 4 && k < 200);
    check("beat4_reached", mon_beat, 4);
    f0 = frames_done;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    apply_reset();
    send_n(7);
    repeat (15) begin @(posedge clk); #1; end
    check("refill_no_frame", frames_done, f0);
    check("refill_busy", bus.busy_out, 0);
    send_n(1);
    wait_frames(f0 + 1, "refill_frame");
    check("refill_base", last_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
